// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU run/step control blocks: FSM state encoding
// and the completed-step counter width.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_STEP   = 3'd1,
      ST_ACK    = 3'd2,
      ST_RUN    = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   localparam int unsigned STEP_CNT_W = 16;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level, with asynchronous
// active-low clear of every stage.
module sync_ff #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ff <= '0;
      end else begin
         ff <= {ff[STAGES-2:0], d};
      end
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/step_ctrl.sv
// Push-button "go" consumer: synchronises go_req, runs the four-phase go_req/go_ack
// handshake and turns each press into a step burst or free run of cpu_en.
// Optional completed-step counter on step_cnt when STEP_CTRL_COUNT_EN is defined.
module step_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned STEP_CYCLES = 1,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  go_req,
   output logic                  go_ack,
   input  logic                  mode_run,
   input  logic                  halt,
   output logic                  cpu_en,
   output logic                  busy,
   output logic [STEP_CNT_W-1:0] step_cnt
);

   state_t     state, nxt;
   logic [7:0] burst, burst_nxt;
   logic       req_s, req_d;
   logic       en_nxt, ack_nxt, busy_nxt;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (go_req),
      .q     (req_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_IDLE;
         burst  <= '0;
         req_d  <= 1'b0;
         cpu_en <= 1'b0;
         go_ack <= 1'b0;
         busy   <= 1'b0;
      end else begin
         state  <= nxt;
         burst  <= burst_nxt;
         req_d  <= req_s;
         cpu_en <= en_nxt;
         go_ack <= ack_nxt;
         busy   <= busy_nxt;
      end
   end

   // Outputs are registered from the next state, so halt sampled at an edge
   // suppresses cpu_en for the cycle that edge would otherwise have started.
   always_comb begin
      nxt       = state;
      burst_nxt = burst;
      case (state)
         ST_IDLE: begin
            if (req_s) begin
               if (halt) begin
                  nxt = ST_ACK;
               end else if (mode_run) begin
                  nxt = ST_RUN;
               end else begin
                  nxt       = ST_STEP;
                  burst_nxt = 8'(STEP_CYCLES);
               end
            end
         end
         ST_STEP: begin
            if (halt) begin
               nxt = ST_HALTED;
            end else if (burst == 8'd1) begin
               nxt = ST_ACK;
            end else begin
               burst_nxt = burst - 8'd1;
            end
         end
         ST_ACK: begin
            if (!req_s) nxt = ST_IDLE;
         end
         ST_RUN: begin
            // The entry press is still visible on req_s for a few cycles;
            // only a fresh rising edge counts as the stop press.
            if (halt) begin
               nxt = ST_HALTED;
            end else if (req_s && !req_d) begin
               nxt = ST_ACK;
            end
         end
         ST_HALTED: begin
            if (req_s) nxt = ST_ACK;
         end
         default: nxt = ST_IDLE;
      endcase

      en_nxt   = (nxt == ST_STEP) || (nxt == ST_RUN);
      ack_nxt  = (nxt == ST_ACK) || ((state == ST_IDLE) && (nxt == ST_RUN));
      busy_nxt = (nxt != ST_IDLE);
   end

`ifdef STEP_CTRL_COUNT_EN
   logic                  step_done;
   logic [STEP_CNT_W-1:0] step_cnt_q;

   assign step_done = (state == ST_STEP) && !halt && (burst == 8'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step_cnt_q <= '0;
      end else if (step_done) begin
         step_cnt_q <= step_cnt_q + STEP_CNT_W'(1);
      end
   end

   assign step_cnt = step_cnt_q;
`else
   assign step_cnt = '0;
`endif

endmodule

// File: tb/tb_step_ctrl.sv
// Self-checking bench for step_ctrl: directed scenarios plus randomized step/run
// sequences against a cycle-count reference model of the press/burst behaviour.
module tb_step_ctrl;

   localparam int unsigned N  = 4;
   localparam int unsigned SS = 2;
`ifdef STEP_CTRL_COUNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, go_req, go_ack, mode_run, halt, cpu_en, busy;
   logic [15:0] step_cnt;
   logic [15:0] model_cnt;
   int          checks = 0;
   int          errors = 0;

   step_ctrl #(.STEP_CYCLES(N), .SYNC_STAGES(SS)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .go_req   (go_req),
      .go_ack   (go_ack),
      .mode_run (mode_run),
      .halt     (halt),
      .cpu_en   (cpu_en),
      .busy     (busy),
      .step_cnt (step_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] exp_cnt();
      return CNT_EN ? model_cnt : 16'h0000;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; go_req = 1'b0; mode_run = 1'b0; halt = 1'b0;
      model_cnt = 16'h0000;
      #22;
      checks++;
      if ({go_ack, cpu_en, busy} !== 3'b000 || step_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL reset_values ack/en/busy=%b cnt=%h exp 000/0000", {go_ack, cpu_en, busy}, step_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick(); tick();
   endtask

   // k = number of enable cycles before halt takes effect; k >= N means no halt.
   task automatic test_step(input int unsigned k);
      int unsigned en_cnt, first_en, last_en, ack_cyc, exp_en, exp_ack;
      bit          contiguous;
      exp_en  = (k < N) ? k : N;
      exp_ack = (k == 0) ? SS + 1 : ((k < N) ? SS + 2 + k : SS + 1 + N);
      en_cnt = 0; first_en = 0; last_en = 0; ack_cyc = 0; contiguous = 1'b1;
      mode_run = 1'b0;
      go_req   = 1'b1;
      for (int unsigned cyc = 1; cyc <= N + 12 && ack_cyc == 0; cyc++) begin
         halt = (k < N) && (cyc == SS + 1 + k);
         if (cyc > SS + 1) mode_run = 1'($urandom);
         tick();
         if (cpu_en === 1'b1) begin
            if (en_cnt > 0 && last_en != cyc - 1) contiguous = 1'b0;
            if (en_cnt == 0) first_en = cyc;
            last_en = cyc;
            en_cnt++;
         end
         if (go_ack === 1'b1) ack_cyc = cyc;
         if (k > 0 && k < N && cyc == SS + 1 + k) begin
            checks++;
            if ({cpu_en, go_ack, busy} !== 3'b001) begin
               errors++;
               $display("FAIL halted_state en/ack/busy=%b exp 001", {cpu_en, go_ack, busy});
            end
         end
      end
      halt = 1'b0; mode_run = 1'b0;
      checks++;
      if (en_cnt != exp_en || !contiguous) begin
         errors++;
         $display("FAIL burst_len k=%0d got %0d contiguous=%0d exp %0d", k, en_cnt, contiguous, exp_en);
      end
      if (exp_en > 0) begin
         checks++;
         if (first_en != SS + 1) begin
            errors++;
            $display("FAIL first_en_latency got %0d exp %0d", first_en, SS + 1);
         end
      end
      checks++;
      if (ack_cyc != exp_ack) begin
         errors++;
         $display("FAIL ack_rise k=%0d got cycle %0d exp %0d", k, ack_cyc, exp_ack);
      end
      if (k >= N) model_cnt = model_cnt + 16'd1;
      go_req = 1'b0;
      tick();
      checks++;
      if (go_ack !== 1'b1) begin
         errors++;
         $display("FAIL ack_hold got %b exp 1", go_ack);
      end
      tick(); tick();
      checks++;
      if ({go_ack, cpu_en, busy} !== 3'b000) begin
         errors++;
         $display("FAIL ack_release ack/en/busy=%b exp 000", {go_ack, cpu_en, busy});
      end
      checks++;
      if (step_cnt !== exp_cnt()) begin
         errors++;
         $display("FAIL step_cnt got %h exp %h", step_cnt, exp_cnt());
      end
   endtask

   // scen 0: second press stops, 1: halt, 2: halt together with second press
   task automatic test_run(input int unsigned scen);
      int unsigned r, bad;
      mode_run = 1'b1;
      go_req   = 1'b1;
      for (int unsigned c = 0; c < SS + 1; c++) tick();
      checks++;
      if ({cpu_en, go_ack, busy} !== 3'b111) begin
         errors++;
         $display("FAIL run_entry en/ack/busy=%b exp 111", {cpu_en, go_ack, busy});
      end
      go_req = 1'b0;
      r = $urandom_range(4, 12);
      bad = 0;
      for (int unsigned c = 0; c < r; c++) begin
         mode_run = 1'($urandom);
         tick();
         if (cpu_en !== 1'b1 || go_ack !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL run_steady bad_cycles=%0d exp 0", bad);
      end
      mode_run = 1'b0;
      if (scen == 0) begin
         go_req = 1'b1;
         tick(); tick();
         checks++;
         if (cpu_en !== 1'b1) begin
            errors++;
            $display("FAIL run_before_stop en=%b exp 1", cpu_en);
         end
         tick();
         checks++;
         if ({cpu_en, go_ack, busy} !== 3'b011) begin
            errors++;
            $display("FAIL run_stop en/ack/busy=%b exp 011", {cpu_en, go_ack, busy});
         end
      end else begin
         if (scen == 2) begin
            go_req = 1'b1;
            tick(); tick();
         end
         halt = 1'b1;
         tick();
         halt = 1'b0;
         checks++;
         if ({cpu_en, go_ack, busy} !== 3'b001) begin
            errors++;
            $display("FAIL run_halt scen=%0d en/ack/busy=%b exp 001", scen, {cpu_en, go_ack, busy});
         end
         if (scen == 1) begin
            for (int unsigned c = 0; c < 4; c++) tick();
            go_req = 1'b1;
            for (int unsigned c = 0; c < SS + 1; c++) tick();
         end else begin
            tick();
         end
         checks++;
         if ({cpu_en, go_ack, busy} !== 3'b011) begin
            errors++;
            $display("FAIL halted_press scen=%0d en/ack/busy=%b exp 011", scen, {cpu_en, go_ack, busy});
         end
      end
      go_req = 1'b0;
      tick(); tick(); tick();
      checks++;
      if ({go_ack, cpu_en, busy} !== 3'b000) begin
         errors++;
         $display("FAIL run_release ack/en/busy=%b exp 000", {go_ack, cpu_en, busy});
      end
   endtask

   task automatic test_reset_mid_burst();
      int unsigned bad;
      mode_run = 1'b0;
      go_req   = 1'b1;
      for (int unsigned c = 0; c < SS + 2; c++) tick();
      checks++;
      if (cpu_en !== 1'b1) begin
         errors++;
         $display("FAIL mid_burst_en got %b exp 1", cpu_en);
      end
      #2;
      rst_n  = 1'b0;
      go_req = 1'b0;
      model_cnt = 16'h0000;
      #1;
      checks++;
      if ({cpu_en, go_ack, busy} !== 3'b000 || step_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL async_reset en/ack/busy=%b cnt=%h exp 000/0000", {cpu_en, go_ack, busy}, step_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      for (int unsigned c = 0; c < 8; c++) begin
         tick();
         if (cpu_en !== 1'b0 || busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL post_reset_idle bad_cycles=%0d exp 0", bad);
      end
   endtask

`ifdef STEP_CTRL_COUNT_EN
   task automatic test_wrap();
      force dut.step_cnt_q = 16'hFFFF;
      #1;
      release dut.step_cnt_q;
      model_cnt = 16'hFFFF;
      test_step(N);
      checks++;
      if (step_cnt !== 16'h0000) begin
         errors++;
         $display("FAIL wrap got %h exp 0000", step_cnt);
      end
   endtask
`endif

   task automatic test_random();
      for (int unsigned it = 0; it < 24; it++) begin
         if ($urandom_range(0, 3) == 0) test_run($urandom_range(0, 2));
         else test_step($urandom_range(0, N + 1));
         for (int unsigned g = $urandom_range(0, 5); g > 0; g--) tick();
      end
   endtask

   initial begin
      test_reset();
      test_step(N);
      test_step(N);
      test_step(2);
      test_step(0);
      test_run(0);
      test_run(1);
      test_run(2);
      test_reset_mid_burst();
      test_step(N);
`ifdef STEP_CTRL_COUNT_EN
      test_wrap();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Consumer side of the push-button "go" request for the single-cycle MIPS CPU. The block synchronises the asynchronous go request level and runs a four-phase request/acknowledge handshake with the latch that produced it. It converts each request into a bounded burst of CPU clock-enable cycles (single-step mode) or a free-running enable (run mode), stopping on a CPU halt. It sits between the board button logic and the CPU core's global enable.

## Interface
- STEP_CYCLES, default 1: cpu_en cycles issued per step request; legal range 1..255.
- SYNC_STAGES, default 2: flops in the go_req synchroniser; legal range 2..3.
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset; assertion clears all state immediately, deassertion takes effect on the next clk edge.
- go_req  in  1  asynchronous request level from the button latch; held high until go_ack clears it.
- go_ack  out  1  acknowledge back to the latch; high clears the latch.
- mode_run  in  1  1 = free run, 0 = single step; sampled only in IDLE.
- halt  in  1  CPU halt (syscall/break), synchronous to clk.
- cpu_en  out  1  CPU global clock enable.
- busy  out  1  high in every state except IDLE.
- step_cnt  out  16  number of completed step bursts, wrapping; present only with the macro.

## Operation
- go_req passes through SYNC_STAGES flops, giving req_s; all decisions use req_s only.
- States: IDLE, STEP, ACK, RUN, HALTED.
- IDLE, req_s=1, mode_run=0: go to STEP and load the burst counter with STEP_CYCLES.
- IDLE, req_s=1, mode_run=1: go to RUN.
- IDLE, req_s=1, halt=1: go to ACK; no cpu_en is issued.
- STEP: cpu_en=1 and the counter decrements each cycle.
  - Counter reaches 1 with halt=0: go to ACK.
  - halt=1 in any STEP cycle: cpu_en is 0 that cycle and the FSM goes to HALTED; the remaining burst is abandoned.
- ACK: go_ack=1, cpu_en=0. Stay until req_s=0, then go to IDLE. This completes the four-phase handshake, so a single press can never produce two bursts.
- RUN: cpu_en=1 while halt=0.
  - go_ack is asserted for one cycle on RUN entry so the latch clears.
  - A new req_s=1 (second press) goes to ACK, which stops the run.
  - halt=1: cpu_en=0 that cycle and the FSM goes to HALTED.
- HALTED: cpu_en=0, go_ack=0. On req_s=1 go to ACK, which resumes nothing and returns to IDLE; the CPU is restarted by a following press.
- Simultaneous halt and req_s=1 in RUN: halt wins and the FSM goes to HALTED.
- mode_run changes outside IDLE are ignored.
- Reset mid-burst: cpu_en, go_ack, busy and the counter are 0 at once; the state is IDLE.

## Timing
- Reset values: go_ack=0, cpu_en=0, busy=0, step_cnt=0, state IDLE, synchroniser flops 0.
- go_req rising to first cpu_en high: SYNC_STAGES+1 cycles (3 with the default).
- Burst length: exactly STEP_CYCLES consecutive cycles when halt=0.
- go_ack rises the cycle after the last cpu_en cycle and stays high until SYNC_STAGES cycles after go_req falls.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- STEP_CTRL_COUNT_EN defined:
  - step_cnt increments by 1 on each STEP→ACK transition, wrapping 16'hFFFF→0.
  - Aborted bursts (STEP→HALTED) do not count.
- Macro undefined: step_cnt is driven to 0 and no counter flops exist.

## Structure
- Shared package cpu_ctrl_pkg holds:
  - the state encoding constants ST_IDLE=0, ST_STEP=1, ST_ACK=2, ST_RUN=3, ST_HALTED=4 (3 bits);
  - the step_cnt width constant (16).
- Sub-module sync_ff: SYNC_STAGES-deep synchroniser with async active-low clear, instantiated once for go_req.
- FSM, burst counter and step counter live in step_ctrl.

## Test plan
- Reset then step: mode_run=0, STEP_CYCLES=1, pulse go_req high → cpu_en high for exactly 1 cycle at cycle 3; go_ack high from cycle 4; drop go_req → go_ack low 2 cycles later; step_cnt=1.
- Burst: STEP_CYCLES=4, two separate presses → 2×4 cpu_en cycles, each burst contiguous; step_cnt=2.
- Halt mid-burst: STEP_CYCLES=8, halt=1 on the 3rd enable cycle → cpu_en high only 2 cycles; state HALTED; step_cnt unchanged.
- Run/stop: mode_run=1, press → cpu_en continuously high with a one-cycle go_ack; second press → cpu_en low; FSM in ACK, then IDLE after release.
- Simultaneous halt and second press in RUN → HALTED, go_ack=0.
- Reset mid-burst: rst_n low during STEP cycle 2 → all outputs 0 immediately; no cpu_en after release until a new press.
- Wrap (macro defined): preload step_cnt to 16'hFFFF via force, one step → 0.
